systolic_seq_ctrl: RTL and testbench
====================================

Name: systolic_seq_ctrl

Overview:
- Host-side sequencer for the `systolic` alignment array.
- Fetches query (S) and reference (T) bases from two external 1-cycle-latency base buffers.
- Splits the query into N-base passes and, for each pass, runs the array's ack/s_update/valid protocol and waits for its busy to fall.
- Reports completion and error status to the top-level host FSM; drives PE_end so the array captures the traceback start on the final pass.

Parameters:
N, 64, number of PEs in the array
LOG_N, 6, log2(N)
BP_WIDTH, 2, bits per base
ADDRESS_WIDTH, 11, base-buffer address width; max sequence length 2^ADDRESS_WIDTH-1
PASS_WIDTH, 5, pass counter width
TIMEOUT, 16, cycles allowed after stream end for array busy to rise

Ports:
clk  in  1  clock
reset_i  in  1  synchronous active-high reset
start  in  1  1-cycle pulse; begin alignment (sampled only in IDLE)
s_len  in  ADDRESS_WIDTH  query length in bases; latched on accepted start
t_len  in  ADDRESS_WIDTH  reference length in bases; latched on accepted start
s_addr  out  ADDRESS_WIDTH  query buffer read address
s_data  in  BP_WIDTH  query base; valid 1 cycle after s_addr
t_addr  out  ADDRESS_WIDTH  reference buffer read address
t_data  in  BP_WIDTH  reference base; valid 1 cycle after t_addr
S  out  BP_WIDTH  to array S
T  out  BP_WIDTH  to array T
s_update  out  1  to array s_update
valid  out  1  to array valid
ack  out  1  to array ack
new_seq  out  1  to array new_seq
PE_end  out  LOG_N  to array PE_end
arr_busy  in  1  array busy
pass_idx  out  PASS_WIDTH  current pass number
ctrl_busy  out  1  high in any state except IDLE
done  out  1  1-cycle pulse on completion
err  out  1  sticky timeout flag; cleared by next accepted start

Behaviour:
- Reset: state IDLE. All outputs 0 except PE_end = N-1. Counters cleared. Reset asserted mid-operation aborts immediately; no done pulse is produced.
- States: IDLE, INIT, ACK, LOAD, STREAM, WAIT_HI, WAIT_LO, FINISH.
- IDLE:
  - start with s_len=0 or t_len=0: go to FINISH; done pulses next cycle; no array traffic.
  - Otherwise: latch lengths, compute npass = ceil(s_len/N), clear err, go to INIT.
  - start in any other state is ignored.
- INIT: new_seq=1 for exactly 1 cycle (pass 0 only). pass_idx=0. Go to ACK.
- ACK: ack=1 for 1 cycle. Go to LOAD.
- LOAD (N+1 cycles):
  - Issue s_addr = pass_idx*N + k for k = 0..N-1.
  - s_update and S are registered so they align with s_data one cycle later: s_update high for exactly N consecutive cycles.
  - Addresses ≥ s_len drive S=0 (padding).
  - Go to STREAM.
- STREAM:
  - Issue t_addr = 0..t_len-1; valid and T aligned to t_data one cycle later, so valid is high for exactly t_len cycles.
  - ack held 1 from the first valid cycle through the last, so the array's read counter advances.
  - T=0 when valid=0.
  - Then go to WAIT_HI with the timeout counter cleared.
- WAIT_HI: wait for arr_busy=1, then go to WAIT_LO. If TIMEOUT cycles elapse first: set err, go to FINISH.
- WAIT_LO: on arr_busy=0:
  - If pass_idx+1 < npass: increment pass_idx, go to ACK.
  - Otherwise go to FINISH.
- FINISH: done=1 for one cycle, go to IDLE.
- PE_end:
  - N-1 on all passes except the last.
  - On the last pass: (s_len-1) mod N, from the low LOG_N bits of s_len-1.
  - Updated on entry to ACK; held stable through WAIT_LO.
- Arithmetic:
  - npass = (s_len + N - 1) >> LOG_N, computed at ADDRESS_WIDTH+1 bits to avoid overflow.
  - Address sums are truncated to ADDRESS_WIDTH.
- ack, s_update, valid and new_seq never overlap, except ack and valid during STREAM.

Test Plan:
1. s_len=64, t_len=100, start → new_seq 1 cycle; ack 1 cycle; s_update 64 cycles with S = buffer[0..63]; valid 100 cycles; PE_end=63; after arr_busy 1→0, done pulses once; pass_idx stays 0.
2. s_len=130, t_len=20 → npass=3. Passes load S addrs 0–63, 64–127, 128–191; addrs 130–191 drive S=0. PE_end = 63, 63, then 1. new_seq appears only in pass 0. done after third busy fall.
3. s_len=0, t_len=50, start → done pulses 2 cycles later; ack, valid, s_update never assert.
4. Array model holds arr_busy=0 after stream → err=1 exactly TIMEOUT cycles after last valid; done pulses; next start with valid lengths clears err.
5. reset_i asserted during LOAD cycle 10 → next cycle all outputs 0, PE_end=63, state IDLE; a subsequent start runs a clean sequence with new_seq.
6. start pulsed again during STREAM and WAIT_LO → ignored: latched lengths, pass_idx and all output waveforms identical to the no-extra-start run.

Source files
------------

// File: rtl/systolic_seq_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_seq_ctrl
//
// Host-side sequencer for the systolic alignment array. It reads query (S) and
// reference (T) bases from two external base buffers with 1-cycle read
// latency. The query is split into N-base passes. For each pass the block runs
// the array's ack / s_update / valid protocol and then waits for the array's
// busy flag to rise and fall. On the final pass PE_end selects the PE that
// holds the last query base, so the array captures its traceback start there.
//
// Handshake with the array (single description for the whole block):
//   new_seq  : one cycle in INIT, first pass only, before any other traffic.
//   ack      : one cycle in ACK at the start of every pass. It is held high
//              again for every cycle in which valid is high.
//   s_update : high for exactly N consecutive cycles per pass, aligned with
//              s_data (one cycle after s_addr). S is 0 for padded addresses.
//   valid    : high for exactly t_len consecutive cycles per pass, aligned
//              with t_data. T is 0 whenever valid is low.
//   These four never overlap, except that ack and valid overlap in STREAM.
//   arr_busy : must rise within TIMEOUT cycles of the last valid cycle.
//              Otherwise err is set and the run finishes.
//
// Ports:
//   clk, reset_i         clock, synchronous active-high reset
//   start, s_len, t_len  run request; lengths are latched when start is accepted
//   s_addr / s_data      query buffer read port (data 1 cycle after address)
//   t_addr / t_data      reference buffer read port (data 1 cycle after address)
//   S, T, s_update, valid, ack, new_seq, PE_end   array control outputs
//   arr_busy             array busy input
//   pass_idx             current pass number
//   ctrl_busy            high in every state except IDLE
//   done                 1-cycle completion pulse, in the cycle after FINISH
//   err                  sticky timeout flag; cleared by the next accepted start
//   dbg_state            current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module systolic_seq_ctrl #(
    parameter int N             = 64,
    parameter int LOG_N         = 6,
    parameter int BP_WIDTH      = 2,
    parameter int ADDRESS_WIDTH = 11,
    parameter int PASS_WIDTH    = 5,
    parameter int TIMEOUT       = 16
) (
    input  logic                     clk,
    input  logic                     reset_i,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] s_len,
    input  logic [ADDRESS_WIDTH-1:0] t_len,
    output logic [ADDRESS_WIDTH-1:0] s_addr,
    input  logic [BP_WIDTH-1:0]      s_data,
    output logic [ADDRESS_WIDTH-1:0] t_addr,
    input  logic [BP_WIDTH-1:0]      t_data,
    output logic [BP_WIDTH-1:0]      S,
    output logic [BP_WIDTH-1:0]      T,
    output logic                     s_update,
    output logic                     valid,
    output logic                     ack,
    output logic                     new_seq,
    output logic [LOG_N-1:0]         PE_end,
    input  logic                     arr_busy,
    output logic [PASS_WIDTH-1:0]    pass_idx,
    output logic                     ctrl_busy,
    output logic                     done,
    output logic                     err,
    output logic [2:0]               dbg_state
);

    // FSM encoding
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] INIT    = 3'd1;
    localparam logic [2:0] ACK     = 3'd2;
    localparam logic [2:0] LOAD    = 3'd3;
    localparam logic [2:0] STREAM  = 3'd4;
    localparam logic [2:0] WAIT_HI = 3'd5;
    localparam logic [2:0] WAIT_LO = 3'd6;
    localparam logic [2:0] FINISH  = 3'd7;

    // Width of the pass count: ceil((2^ADDRESS_WIDTH - 1) / N) needs one bit
    // more than the pass index once the sum is done at ADDRESS_WIDTH+1 bits.
    localparam int NPW = ADDRESS_WIDTH + 1 - LOG_N;
    localparam int TW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [ADDRESS_WIDTH-1:0] N_A      = ADDRESS_WIDTH'(N);
    localparam logic [LOG_N-1:0]         PE_FULL  = LOG_N'(N - 1);
    // The counter starts at 0 in the first cycle after the last valid cycle.
    // Firing on TIMEOUT-2 makes err visible exactly TIMEOUT cycles after the
    // last valid cycle.
    localparam logic [TW-1:0]            TO_LAST  = TW'(TIMEOUT - 2);

    logic [2:0]               state;
    logic [ADDRESS_WIDTH-1:0] cnt;        // beat counter shared by LOAD and STREAM
    logic [TW-1:0]            to_cnt;     // WAIT_HI timeout counter
    logic [PASS_WIDTH-1:0]    pass_idx_q;
    logic [NPW-1:0]           npass_q;
    logic [ADDRESS_WIDTH-1:0] s_len_q;
    logic [ADDRESS_WIDTH-1:0] t_len_q;
    logic [LOG_N-1:0]         pe_end_q;
    logic                     s_upd_q;    // s_update, delayed to match s_data
    logic                     s_pad_q;    // current S beat lies past s_len
    logic                     valid_q;    // valid, delayed to match t_data
    logic                     done_q;
    logic                     err_q;

    // Combinational helpers
    logic [ADDRESS_WIDTH:0]   npass_sum;
    logic [NPW-1:0]           npass_calc;
    logic [ADDRESS_WIDTH-1:0] s_addr_calc;
    logic                     issue_s;
    logic                     issue_t;
    logic                     more_passes;
    logic                     next_is_last;
    logic [LOG_N-1:0]         last_pe;

    // npass = ceil(s_len / N). The sum is done one bit wider so that lengths
    // near 2^ADDRESS_WIDTH do not wrap.
    always_comb begin
        npass_sum  = {1'b0, s_len} + (ADDRESS_WIDTH + 1)'(N - 1);
        npass_calc = NPW'(npass_sum >> LOG_N);
    end

    // Query address = pass_idx*N + beat, truncated to the buffer width.
    always_comb begin
        s_addr_calc = ADDRESS_WIDTH'({pass_idx_q, {LOG_N{1'b0}}}) + cnt;
    end

    // LOAD issues addresses on beats 0..N-1. Beat N only lets the last
    // registered s_update drain. STREAM works the same way with t_len.
    always_comb begin
        issue_s = (state == LOAD)   && (cnt < N_A);
        issue_t = (state == STREAM) && (cnt < t_len_q);
    end

    // Pass bookkeeping. The pass index is widened to the pass-count width so
    // that pass_idx+2 cannot wrap.
    always_comb begin
        more_passes  = (NPW'(pass_idx_q) + NPW'(1)) <  npass_q;
        next_is_last = (NPW'(pass_idx_q) + NPW'(2)) >= npass_q;
        last_pe      = LOG_N'(s_len_q - ADDRESS_WIDTH'(1));
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state      <= IDLE;
            cnt        <= '0;
            to_cnt     <= '0;
            pass_idx_q <= '0;
            npass_q    <= '0;
            s_len_q    <= '0;
            t_len_q    <= '0;
            pe_end_q   <= PE_FULL;
            s_upd_q    <= 1'b0;
            s_pad_q    <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // Address-phase strobes become data-phase strobes one cycle later.
            s_upd_q <= issue_s;
            s_pad_q <= issue_s && (s_addr_calc >= s_len_q);
            valid_q <= issue_t;
            done_q  <= (state == FINISH);

            case (state)
                IDLE: begin
                    if (start) begin
                        err_q      <= 1'b0;
                        pass_idx_q <= '0;
                        cnt        <= '0;
                        s_len_q    <= s_len;
                        t_len_q    <= t_len;
                        npass_q    <= npass_calc;
                        // An empty sequence completes without array traffic.
                        if ((s_len == '0) || (t_len == '0)) begin
                            state <= FINISH;
                        end else begin
                            state <= INIT;
                        end
                    end
                end

                INIT: begin
                    pe_end_q <= (npass_q == NPW'(1)) ? last_pe : PE_FULL;
                    state    <= ACK;
                end

                ACK: begin
                    cnt   <= '0;
                    state <= LOAD;
                end

                LOAD: begin
                    if (cnt == N_A) begin
                        cnt   <= '0;
                        state <= STREAM;
                    end else begin
                        cnt <= cnt + ADDRESS_WIDTH'(1);
                    end
                end

                STREAM: begin
                    if (cnt == t_len_q) begin
                        cnt    <= '0;
                        to_cnt <= '0;
                        state  <= WAIT_HI;
                    end else begin
                        cnt <= cnt + ADDRESS_WIDTH'(1);
                    end
                end

                WAIT_HI: begin
                    if (arr_busy) begin
                        state <= WAIT_LO;
                    end else if (to_cnt == TO_LAST) begin
                        err_q <= 1'b1;
                        state <= FINISH;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end

                WAIT_LO: begin
                    if (!arr_busy) begin
                        if (more_passes) begin
                            pass_idx_q <= pass_idx_q + PASS_WIDTH'(1);
                            pe_end_q   <= next_is_last ? last_pe : PE_FULL;
                            state      <= ACK;
                        end else begin
                            state <= FINISH;
                        end
                    end
                end

                FINISH: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output decode. Every term comes from a register. S and T gate the buffer
    // data with the delayed strobes, so they read 0 outside their windows.
    always_comb begin
        s_addr    = issue_s ? s_addr_calc : '0;
        t_addr    = issue_t ? cnt : '0;
        s_update  = s_upd_q;
        S         = (s_upd_q && !s_pad_q) ? s_data : '0;
        valid     = valid_q;
        T         = valid_q ? t_data : '0;
        ack       = (state == ACK) || valid_q;
        new_seq   = (state == INIT);
        PE_end    = pe_end_q;
        pass_idx  = pass_idx_q;
        ctrl_busy = (state != IDLE);
        done      = done_q;
        err       = err_q;
        dbg_state = state;
    end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_seq_ctrl
//
// Bench for systolic_seq_ctrl. It contains:
//   - two 1-cycle-latency base buffers filled with random bases;
//   - a responsive array model that raises arr_busy a random time after the
//     stream ends, or never raises it in hang mode;
//   - a negedge monitor that records S/T beats, strobe run lengths, PE_end per
//     pass and protocol violations;
//   - a reference model that builds the expected S/T/PE_end/pass queues from
//     the sequence lengths using plain arithmetic.
// -----------------------------------------------------------------------------
module tb_systolic_seq_ctrl;

    localparam int N        = 64;
    localparam int LOG_N    = 6;
    localparam int BPW      = 2;
    localparam int AW       = 11;
    localparam int PW       = 5;
    localparam int TIMEOUT  = 16;
    localparam int BUDGET   = 5000;

    // clock / reset
    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // DUT signals
    logic          start;
    logic [AW-1:0] s_len, t_len, s_addr, t_addr;
    logic [BPW-1:0] s_data, t_data, S, T;
    logic          s_update, valid, ack, new_seq, arr_busy;
    logic [LOG_N-1:0] PE_end;
    logic [PW-1:0] pass_idx;
    logic          ctrl_busy, done, err;
    logic [2:0]    dbg_state;

    systolic_seq_ctrl #(
        .N(N), .LOG_N(LOG_N), .BP_WIDTH(BPW), .ADDRESS_WIDTH(AW),
        .PASS_WIDTH(PW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_i(reset_i), .start(start), .s_len(s_len), .t_len(t_len),
        .s_addr(s_addr), .s_data(s_data), .t_addr(t_addr), .t_data(t_data),
        .S(S), .T(T), .s_update(s_update), .valid(valid), .ack(ack),
        .new_seq(new_seq), .PE_end(PE_end), .arr_busy(arr_busy),
        .pass_idx(pass_idx), .ctrl_busy(ctrl_busy), .done(done), .err(err),
        .dbg_state(dbg_state)
    );

    // base buffers
    logic [BPW-1:0] s_mem [2**AW];
    logic [BPW-1:0] t_mem [2**AW];
    always @(posedge clk) begin
        s_data <= s_mem[s_addr];
        t_data <= t_mem[t_addr];
    end

    // array model
    bit hang_mode = 1'b0;
    initial begin : array_model
        bit saw_v;
        saw_v    = 1'b0;
        arr_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (valid) begin
                saw_v = 1'b1;
            end else if (saw_v) begin
                saw_v = 1'b0;
                if (!hang_mode) begin
                    repeat ($urandom_range(0, 8)) @(negedge clk);
                    arr_busy = 1'b1;
                    repeat ($urandom_range(1, 6)) @(negedge clk);
                    arr_busy = 1'b0;
                end
            end
        end
    end

    // scoreboard counters and checking task
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // monitor
    bit             mon_en = 1'b0;
    logic [BPW-1:0] got_s [$];
    logic [BPW-1:0] got_t [$];
    int             s_runs [$];
    int             v_runs [$];
    logic [LOG_N-1:0] got_pe [$];
    logic [PW-1:0]  got_pidx [$];
    int s_run, v_run, n_new, n_ack, n_done, viol;
    int done_cyc, last_v_cyc, err_cyc;
    logic prev_err;

    always @(negedge clk) begin
        if (mon_en) begin
            int sum;
            if (s_update) begin
                got_s.push_back(S);
                s_run++;
            end else if (s_run != 0) begin
                s_runs.push_back(s_run);
                s_run = 0;
            end
            if (valid) begin
                got_t.push_back(T);
                v_run++;
                last_v_cyc = cyc;
            end else if (v_run != 0) begin
                v_runs.push_back(v_run);
                v_run = 0;
            end
            if (new_seq) n_new++;
            if (ack) n_ack++;
            if (ack && !valid) begin
                got_pe.push_back(PE_end);
                got_pidx.push_back(pass_idx);
            end
            sum = int'(ack) + int'(s_update) + int'(valid) + int'(new_seq);
            if (sum > 1 && !(sum == 2 && ack && valid)) viol++;
            if (valid && !ack) viol++;
            if (!valid && T != '0) viol++;
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (err && !prev_err) err_cyc = cyc;
            prev_err = err;
        end
    end

    task automatic clear_mon();
        got_s.delete(); got_t.delete(); s_runs.delete(); v_runs.delete();
        got_pe.delete(); got_pidx.delete();
        s_run = 0; v_run = 0; n_new = 0; n_ack = 0; n_done = 0; viol = 0;
        done_cyc = -1; last_v_cyc = -1; err_cyc = -1; prev_err = err;
    endtask

    // One alignment run. The reference model derives everything from sl/tl.
    task automatic run_seq(input int sl, input int tl, input bit hang, input bit extra);
        int np, ep, start_cyc, c;
        bit pulsed_v, pulsed_b;
        logic [BPW-1:0] exp_q [$];
        logic [BPW-1:0] exp_t [$];
        logic [LOG_N-1:0] exp_pe [$];
        clear_mon();
        hang_mode = hang;
        mon_en    = 1'b1;
        @(negedge clk);
        s_len = AW'(sl); t_len = AW'(tl); start = 1'b1; start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        s_len = AW'($urandom_range(1, 2047));
        t_len = AW'($urandom_range(1, 2047));
        pulsed_v = 1'b0; pulsed_b = 1'b0;
        for (c = 0; c < BUDGET && n_done == 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (extra && valid && !pulsed_v) begin
                pulsed_v = 1'b1; start = 1'b1;
                s_len = AW'($urandom_range(1, 2047)); t_len = AW'($urandom_range(1, 2047));
            end else if (extra && arr_busy && !pulsed_b) begin
                pulsed_b = 1'b1; start = 1'b1;
                s_len = AW'($urandom_range(1, 2047)); t_len = AW'($urandom_range(1, 2047));
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 1'b0;

        // reference model
        np = (sl == 0 || tl == 0) ? 0 : (sl + N - 1) / N;
        ep = (hang && np > 0) ? 1 : np;
        for (int p = 0; p < ep; p++) begin
            for (int k = 0; k < N; k++) begin
                int a;
                a = p * N + k;
                exp_q.push_back((a < sl) ? s_mem[a] : '0);
            end
            for (int k = 0; k < tl; k++) exp_t.push_back(t_mem[k]);
            exp_pe.push_back((p == np - 1) ? LOG_N'((sl - 1) % N) : LOG_N'(N - 1));
        end

        chk("done_count", n_done, 1);
        chk("new_seq_count", n_new, (ep > 0) ? 1 : 0);
        chk("ack_count", n_ack, ep * (1 + tl));
        chk("protocol_viol", viol, 0);
        chk("err_final", err, hang);
        chk("s_run_count", s_runs.size(), ep);
        foreach (s_runs[i]) chk("s_run_len", s_runs[i], N);
        chk("v_run_count", v_runs.size(), ep);
        foreach (v_runs[i]) chk("v_run_len", v_runs[i], tl);
        chk("s_beats", got_s.size(), exp_q.size());
        for (int i = 0; i < got_s.size() && i < exp_q.size(); i++) chk("s_value", got_s[i], exp_q[i]);
        chk("t_beats", got_t.size(), exp_t.size());
        for (int i = 0; i < got_t.size() && i < exp_t.size(); i++) chk("t_value", got_t[i], exp_t[i]);
        chk("pass_count", got_pe.size(), exp_pe.size());
        for (int i = 0; i < got_pe.size() && i < exp_pe.size(); i++) begin
            chk("pe_end", got_pe[i], exp_pe[i]);
            chk("pass_idx", got_pidx[i], i);
        end
        if (np == 0) chk("empty_done_latency", done_cyc - start_cyc, 2);
        if (hang) chk("timeout_latency", err_cyc - last_v_cyc, TIMEOUT);
        chk("idle_after_done", ctrl_busy, 0);
    endtask

    // Reset while the query buffer is being read; no done may follow.
    task automatic reset_mid_load();
        int seen, dcnt;
        @(negedge clk);
        s_len = AW'(64); t_len = AW'(100); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && !s_update; c++) @(negedge clk);
        chk("load_reached", s_update, 1);
        repeat (9) @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        chk("rst_s_update", s_update, 0);
        chk("rst_valid", valid, 0);
        chk("rst_ack", ack, 0);
        chk("rst_new_seq", new_seq, 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_S", S, 0);
        chk("rst_pe_end", PE_end, N - 1);
        chk("rst_busy", ctrl_busy, 0);
        chk("rst_pass_idx", pass_idx, 0);
        reset_i = 1'b0;
        dcnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("no_done_after_reset", dcnt, 0);
    endtask

    // watchdog
    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1);
    end

    // main sequence
    initial begin
        reset_i = 1'b1; start = 1'b0; s_len = '0; t_len = '0;
        for (int i = 0; i < 2**AW; i++) begin
            s_mem[i] = BPW'($urandom);
            t_mem[i] = BPW'($urandom);
        end
        repeat (3) @(negedge clk);
        chk("reset_pe_end", PE_end, N - 1);
        chk("reset_busy", ctrl_busy, 0);
        chk("reset_ack", ack, 0);
        chk("reset_valid", valid, 0);
        chk("reset_s_update", s_update, 0);
        chk("reset_new_seq", new_seq, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_pass_idx", pass_idx, 0);
        reset_i = 1'b0;

        run_seq(64, 100, 1'b0, 1'b0);
        run_seq(130, 20, 1'b0, 1'b0);
        run_seq(0, 50, 1'b0, 1'b0);
        run_seq(50, 0, 1'b0, 1'b0);
        run_seq(1, 1, 1'b0, 1'b0);
        run_seq(65, 7, 1'b0, 1'b0);
        run_seq(100, 30, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        chk("err_sticky", err, 1);
        run_seq(70, 10, 1'b0, 1'b0);
        reset_mid_load();
        run_seq(64, 16, 1'b0, 1'b0);
        run_seq(130, 20, 1'b0, 1'b1);
        for (int r = 0; r < 6; r++) begin
            run_seq($urandom_range(1, 300), $urandom_range(1, 120), 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
